// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmitter with a one-entry holding register.
//
// Words are accepted over a valid/ready handshake into a holding register and then
// serialized LSB-first as a start bit, WORD_SIZE data bits, an optional parity bit and
// STOP_BITS stop bits. While a frame is on the line the next word can already be queued,
// so consecutive frames follow each other with no idle gap.
//
// Ports:
//   clk         system clock
//   reset_b     asynchronous active-low reset; aborts any frame, line returns high
//   tx_data_in  word to send, sampled only on acceptance
//   tx_valid    producer has a word on tx_data_in
//   tx_ready    holding register empty (driven straight from the hold_full flop)
//   tx_out      serial line, idles high (registered)
//   tx_busy     high while the FSM is outside idle (registered)
//   tx_done     one-cycle pulse on the last cycle of the final stop bit (registered)

module uart_tx_serializer #(
  parameter int unsigned WORD_SIZE    = 8,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic [WORD_SIZE-1:0] tx_data_in,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

  localparam logic [CntW-1:0] CntMax   = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxMax   = IdxW'(WORD_SIZE - 1);
  localparam logic            StopLast = 1'(STOP_BITS - 1);
  localparam logic            ParOdd   = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [WORD_SIZE-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   stop_q, stop_d;
  logic [WORD_SIZE-1:0]   hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic                   tx_out_q, tx_out_d;
  logic                   tx_busy_q, tx_busy_d;
  logic                   tx_done_q, tx_done_d;

  logic                   bit_end;
  logic                   load;
  logic                   accept;

  assign bit_end = (cnt_q == CntMax);
  assign accept  = tx_valid && !hold_full_q;

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    stop_d  = stop_q;
    load    = 1'b0;

    // Baud counter free-runs through every bit of a frame and wraps at each bit end.
    if (state_q != StIdle) begin
      cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (hold_full_q) begin
          load = 1'b1;
        end
      end

      StStart: begin
        if (bit_end) begin
          state_d = StData;
          idx_d   = '0;
        end
      end

      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IdxMax) begin
            stop_d  = 1'b0;
            state_d = (PARITY_EN != 0) ? StParity : StStop;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end

      StParity: begin
        if (bit_end) begin
          stop_d  = 1'b0;
          state_d = StStop;
        end
      end

      StStop: begin
        if (bit_end) begin
          if (stop_q == StopLast) begin
            // A queued word starts its start bit right after the last stop bit.
            if (hold_full_q) begin
              load = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Loading takes the word out of the holding register; parity is fixed here from the
    // whole word since the shifter is destroyed as the data bits go out.
    if (load) begin
      state_d = StStart;
      cnt_d   = '0;
      shift_d = hold_q;
      par_d   = (^hold_q) ^ ParOdd;
    end
  end

  // Holding register: a drain only happens while full, and an accept only while empty,
  // so the two never coincide.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (load) begin
      hold_full_d = 1'b0;
    end else if (accept) begin
      hold_d      = tx_data_in;
      hold_full_d = 1'b1;
    end
  end

  // Outputs are registered, so they are decoded from the next-state values.
  always_comb begin
    tx_out_d = 1'b1;
    case (state_d)
      StStart:  tx_out_d = 1'b0;
      StData:   tx_out_d = shift_d[0];
      StParity: tx_out_d = par_d;
      default:  tx_out_d = 1'b1;
    endcase
    tx_busy_d = (state_d != StIdle);
    tx_done_d = (state_d == StStop) && (cnt_d == CntMax) && (stop_d == StopLast);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      stop_q      <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_out_q    <= 1'b1;
      tx_busy_q   <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      stop_q      <= stop_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_out_q    <= tx_out_d;
      tx_busy_q   <= tx_busy_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign tx_ready = !hold_full_q;
  assign tx_out   = tx_out_q;
  assign tx_busy  = tx_busy_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four instances at CLKS_PER_BIT=4 cover the plain 8N1,
// even parity, odd parity and two-stop-bit configurations. Stimulus pushes the expected
// word (with its hand-computed parity bit) into a per-instance queue; an independent
// monitor per instance watches the line, pops on each start bit and checks the frame.

module tb_uart_tx_serializer;

  localparam int unsigned NDut = 4;
  localparam int unsigned Cpb  = 4;
  localparam int unsigned PE_TAB [NDut] = '{0, 1, 1, 0};
  localparam int unsigned PO_TAB [NDut] = '{0, 0, 1, 0};
  localparam int unsigned SB_TAB [NDut] = '{1, 1, 1, 2};

  typedef struct packed {
    logic [7:0] data;
    logic       par;
  } exp_t;

  logic            clk;
  logic            reset_b;
  logic [NDut-1:0] valid;
  logic [7:0]      din [NDut];
  logic [NDut-1:0] ready;
  logic [NDut-1:0] txo;
  logic [NDut-1:0] busy;
  logic [NDut-1:0] done;

  exp_t exp_q [NDut][$];
  int   done_cnt  [NDut];
  int   done_last [NDut];
  int   done_prev [NDut];
  int   cyc;
  int   tests;
  int   fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  for (genvar g = 0; g < NDut; g++) begin : g_ch
    localparam int unsigned Pe = PE_TAB[g];
    localparam int unsigned Sb = SB_TAB[g];
    localparam int unsigned Nb = 1 + 8 + Pe + Sb;

    uart_tx_serializer #(
      .WORD_SIZE   (8),
      .CLKS_PER_BIT(Cpb),
      .PARITY_EN   (Pe),
      .PARITY_ODD  (PO_TAB[g]),
      .STOP_BITS   (Sb)
    ) u_dut (
      .clk       (clk),
      .reset_b   (reset_b),
      .tx_data_in(din[g]),
      .tx_valid  (valid[g]),
      .tx_ready  (ready[g]),
      .tx_out    (txo[g]),
      .tx_busy   (busy[g]),
      .tx_done   (done[g])
    );

    initial begin : mon
      exp_t        e;
      logic [15:0] expv;
      logic [15:0] rxv;
      int          glitch;
      int          bad_busy;
      int          bad_done;
      bit          armed;
      bit          aborted;
      armed = 1'b0;
      forever begin
        if (!armed) @(negedge clk);
        armed = 1'b0;
        if (reset_b === 1'b1 && txo[g] === 1'b0) begin
          e = '0;
          if (exp_q[g].size() == 0) begin
            chk($sformatf("d%0d_unexpected_frame", g), 32'(exp_q[g].size()), 32'd1);
          end else begin
            e = exp_q[g].pop_front();
          end
          expv       = '1;
          expv[0]    = 1'b0;
          expv[8:1]  = e.data;
          if (Pe != 0) expv[9] = e.par;
          rxv      = '1;
          glitch   = 0;
          bad_busy = 0;
          bad_done = 0;
          aborted  = 1'b0;
          for (int b = 0; b < Nb; b++) begin
            for (int c = 0; c < Cpb; c++) begin
              if (!aborted) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (reset_b !== 1'b1) begin
                  aborted = 1'b1;
                end else begin
                  if (c == 0) rxv[b] = txo[g];
                  else if (txo[g] !== rxv[b]) glitch++;
                  if (busy[g] !== 1'b1) bad_busy++;
                  if (done[g] !== ((b == Nb - 1) && (c == Cpb - 1))) bad_done++;
                  if (done[g] === 1'b1) begin
                    done_cnt[g]++;
                    done_prev[g] = done_last[g];
                    done_last[g] = cyc;
                  end
                end
              end
            end
          end
          if (!aborted) begin
            chk($sformatf("d%0d_frame_bits", g), 32'(rxv), 32'(expv));
            chk($sformatf("d%0d_bit_glitches", g), 32'(glitch), 32'd0);
            chk($sformatf("d%0d_busy_in_frame", g), 32'(bad_busy), 32'd0);
            chk($sformatf("d%0d_done_position", g), 32'(bad_done), 32'd0);
            @(negedge clk);
            if (reset_b === 1'b1) begin
              // Either idle (line high, not busy) or the next start bit (line low, busy).
              chk($sformatf("d%0d_post_frame_busy", g), 32'(busy[g]), 32'(!txo[g]));
              armed = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic send(input int g, input logic [7:0] d, input logic p);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (ready[g] !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("d%0d_send_ready_timeout", g), 32'(n < 2000), 32'd1);
    e.data = d;
    e.par  = p;
    exp_q[g].push_back(e);
    valid[g] = 1'b1;
    din[g]   = d;
    @(negedge clk);
    valid[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy[g] === 1'b0 && ready[g] === 1'b1 && exp_q[g].size() == 0) && n < 3000);
    chk($sformatf("d%0d_idle_timeout", g), 32'(n < 3000), 32'd1);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #400000;
    fails++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : stim
    int c0;
    int k;
    int n;
    tests   = 0;
    fails   = 0;
    reset_b = 1'b0;
    valid   = '0;
    for (int i = 0; i < NDut; i++) din[i] = 8'h00;

    // Reset held with a word offered.
    valid[0] = 1'b1;
    din[0]   = 8'hEE;
    repeat (3) @(negedge clk);
    chk("rst_tx_out", 32'(txo[0]), 32'd1);
    chk("rst_tx_ready", 32'(ready[0]), 32'd1);
    chk("rst_tx_busy", 32'(busy[0]), 32'd0);
    chk("rst_tx_done", 32'(done[0]), 32'd0);
    valid[0] = 1'b0;
    reset_b  = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_capture_ready", 32'(ready[0]), 32'd1);
    chk("rst_no_capture_busy", 32'(busy[0]), 32'd0);

    // Single frame 0xA5 with acceptance-to-start latency.
    send(0, 8'hA5, 1'b0);
    chk("acc_ready_low", 32'(ready[0]), 32'd0);
    chk("acc_line_idle", 32'(txo[0]), 32'd1);
    chk("acc_not_busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    chk("start_line_low", 32'(txo[0]), 32'd0);
    chk("start_busy", 32'(busy[0]), 32'd1);
    chk("start_ready_back", 32'(ready[0]), 32'd1);
    wait_idle(0);

    // Parity (0x07 has three ones) and two stop bits, run concurrently on other instances.
    send(1, 8'h07, 1'b1);
    send(2, 8'h07, 1'b0);
    send(3, 8'h55, 1'b0);
    wait_idle(1);
    wait_idle(2);
    wait_idle(3);

    // Back-to-back: second word queued while the first is in its data bits.
    c0 = done_cnt[0];
    send(0, 8'h00, 1'b0);
    repeat (8) @(negedge clk);
    send(0, 8'hFF, 1'b0);
    wait_idle(0);
    chk("b2b_done_count", 32'(done_cnt[0] - c0), 32'd2);
    chk("b2b_done_spacing", 32'(done_last[0] - done_prev[0]), 32'd40);

    // Backpressure: data churns while not ready; only the value at the accepting edge counts.
    send(0, 8'h81, 1'b0);
    send(0, 8'h42, 1'b0);
    chk("bp_ready_low", 32'(ready[0]), 32'd0);
    valid[0] = 1'b1;
    k = 0;
    n = 0;
    while (ready[0] !== 1'b1 && n < 2000) begin
      din[0] = 8'h10 + 8'(k);
      k++;
      @(negedge clk);
      n++;
    end
    chk("bp_ready_timeout", 32'(n < 2000), 32'd1);
    begin
      exp_t e;
      e.data = 8'h3C;
      e.par  = 1'b0;
      exp_q[0].push_back(e);
    end
    din[0] = 8'h3C;
    @(negedge clk);
    valid[0] = 1'b0;
    din[0]   = 8'h99;
    wait_idle(0);

    // Reset in the middle of the data bits, then a clean frame.
    send(0, 8'h5A, 1'b0);
    repeat (14) @(negedge clk);
    #2;
    reset_b = 1'b0;
    #1;
    chk("midrst_tx_out", 32'(txo[0]), 32'd1);
    chk("midrst_tx_ready", 32'(ready[0]), 32'd1);
    chk("midrst_tx_busy", 32'(busy[0]), 32'd0);
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    send(0, 8'hC3, 1'b0);
    wait_idle(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
